// File: rtl/rect_draw_arbiter.sv
// Round-robin arbiter for four rectangle-fill requesters feeding one pixel writer.
// A granted job is rasterised row-major, one pixel per clock, with off-screen pixels masked.
module rect_draw_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [31:0] req_x,
    input  logic [27:0] req_y,
    input  logic [31:0] req_w,
    input  logic [27:0] req_h,
    input  logic [11:0] req_colour,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        busy,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  cx_q, cx_d;
    logic [6:0]  cy_q, cy_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic        busy_q, busy_d;
    logic        plot_q, plot_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;

    logic [7:0]  job_x_q, job_x_d;
    logic [6:0]  job_y_q, job_y_d;
    logic [7:0]  job_w_q, job_w_d;
    logic [6:0]  job_h_q, job_h_d;
    logic [2:0]  job_c_q, job_c_d;

    logic        found;
    logic [1:0]  sel;
    logic [1:0]  idx;
    logic [7:0]  px;
    logic [6:0]  py;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        gnt_d    = 4'b0000;
        done_d   = 4'b0000;
        busy_d   = 1'b0;
        plot_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        job_x_d  = job_x_q;
        job_y_d  = job_y_q;
        job_w_d  = job_w_q;
        job_h_d  = job_h_q;
        job_c_d  = job_c_q;
        found    = 1'b0;
        sel      = last_q;
        idx      = last_q;
        px       = job_x_q + cx_q;
        py       = job_y_q + cy_q;

        // Search starts one past the previous winner so every pending requester gets a turn.
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = DRAW;
                    gnt_d   = 4'b0001 << sel;
                    last_d  = sel;
                    busy_d  = 1'b1;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                    job_x_d = req_x[8*sel +: 8];
                    job_y_d = req_y[7*sel +: 7];
                    job_w_d = req_w[8*sel +: 8];
                    job_h_d = req_h[7*sel +: 7];
                    job_c_d = req_colour[3*sel +: 3];
                end
            end
            DRAW: begin
                // busy stays up on the final pixel so it covers the done edge as well.
                busy_d   = 1'b1;
                x_d      = px;
                y_d      = py;
                colour_d = job_c_q;
                plot_d   = (int'({24'd0, px}) < SCREEN_W) && (int'({25'd0, py}) < SCREEN_H);
                if (cx_q == job_w_q) begin
                    cx_d = 8'd0;
                    if (cy_q == job_h_q) begin
                        done_d  = 4'b0001 << last_q;
                        state_d = IDLE;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            last_q   <= 2'd3;
            cx_q     <= 8'd0;
            cy_q     <= 7'd0;
            gnt_q    <= 4'b0000;
            done_q   <= 4'b0000;
            busy_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end

    // Job fields are pure data and only meaningful once a grant has loaded them.
    always_ff @(posedge clock) begin
        job_x_q <= job_x_d;
        job_y_q <= job_y_d;
        job_w_q <= job_w_d;
        job_h_q <= job_h_d;
        job_c_q <= job_c_d;
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Directed bench for rect_draw_arbiter: single jobs, round-robin, clipping, field freeze, reset.
module tb_rect_draw_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_x = '0;
    logic [27:0] req_y = '0;
    logic [31:0] req_w = '0;
    logic [27:0] req_h = '0;
    logic [11:0] req_colour = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    int passes = 0;
    int fails  = 0;

    rect_draw_arbiter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
        .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .gnt(gnt), .done(done),
        .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_job(input int i, input int jx, input int jy, input int jw,
                           input int jh, input int jc);
        req_x[8*i +: 8]      = 8'(jx);
        req_y[7*i +: 7]      = 7'(jy);
        req_w[8*i +: 8]      = 8'(jw);
        req_h[7*i +: 7]      = 7'(jh);
        req_colour[3*i +: 3] = 3'(jc);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_plot"}, 32'(plot), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_x"},    32'(x), 0);
        chk({tag, "_y"},    32'(y), 0);
        chk({tag, "_col"},  32'(colour), 0);
    endtask

    initial begin
        int busy_cnt, ones, errs, plots, done_at, ex, ey, ep;

        // Power-on reset, checked asynchronously before any clock edge.
        #2 resetn = 1'b0;
        #5 chk_idle_outputs("rst");
        tick();
        resetn = 1'b1;
        tick();
        chk("idle_gnt", 32'(gnt), 0);

        // Single 16x2 job from requester 0; requester 1 raises req mid-job.
        set_job(0, 76, 110, 15, 1, 7);
        set_job(1, 1, 2, 0, 0, 3);
        req = 4'b0001;
        tick();
        chk("j50_gnt", 32'(gnt), 1);
        chk("j50_busy0", 32'(busy), 1);
        chk("j50_plot0", 32'(plot), 0);
        req = 4'b0000;
        busy_cnt = 1;
        for (int k = 0; k < 32; k++) begin
            if (k == 5) req = 4'b0010;
            tick();
            chk("j50_x", 32'(x), 32'(76 + k % 16));
            chk("j50_y", 32'(y), 32'(110 + k / 16));
            chk("j50_plot", 32'(plot), 1);
            chk("j50_col", 32'(colour), 7);
            chk("j50_gnt_frozen", 32'(gnt), 0);
            chk("j50_done", 32'(done), (k == 31) ? 1 : 0);
            if (busy) busy_cnt++;
        end
        chk("j50_busy_cnt", 32'(busy_cnt), 33);
        tick();
        chk("j29_regnt", 32'(gnt), 2);
        chk("j29_plot_gap", 32'(plot), 0);
        chk("j29_done_gap", 32'(done), 0);
        req = 4'b0000;
        tick();
        chk("j29_x", 32'(x), 1);
        chk("j29_y", 32'(y), 2);
        chk("j29_col", 32'(colour), 3);
        chk("j29_done", 32'(done), 2);
        tick();
        chk("j29_busy_end", 32'(busy), 0);
        chk("j29_plot_end", 32'(plot), 0);

        // Reset to restore first priority to requester 0, then all four request 1x1 jobs.
        resetn = 1'b0;
        #2 chk_idle_outputs("rst2");
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) set_job(i, 10 + i, 5, 0, 0, i);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(1 << i));
            chk("rr_busy", 32'(busy), 1);
            req[i] = 1'b0;
            tick();
            chk("rr_done", 32'(done), 32'(1 << i));
            chk("rr_x", 32'(x), 32'(10 + i));
            chk("rr_col", 32'(colour), 32'(i));
            chk("rr_plot", 32'(plot), 1);
            chk("rr_gnt_gap", 32'(gnt), 0);
        end
        tick();
        chk("rr_end_gnt", 32'(gnt), 0);
        chk("rr_end_busy", 32'(busy), 0);

        // Clipping at the bottom-right corner.
        set_job(2, 155, 118, 7, 3, 5);
        req = 4'b0100;
        tick();
        chk("clip_gnt", 32'(gnt), 4);
        req = 4'b0000;
        ones = 0;
        for (int cy = 0; cy < 4; cy++) begin
            for (int cx = 0; cx < 8; cx++) begin
                tick();
                ex = (155 + cx) % 256;
                ey = (118 + cy) % 128;
                ep = (ex < 160 && ey < 120) ? 1 : 0;
                chk("clip_x", 32'(x), 32'(ex));
                chk("clip_y", 32'(y), 32'(ey));
                chk("clip_plot", 32'(plot), 32'(ep));
                chk("clip_done", 32'(done), (cx == 7 && cy == 3) ? 4 : 0);
                ones += int'(plot);
            end
        end
        chk("clip_ones", 32'(ones), 10);

        // Fields changed after the grant must not reach the pixel.
        set_job(3, 80, 108, 0, 0, 6);
        req = 4'b1000;
        tick();
        chk("ball_gnt", 32'(gnt), 8);
        req_x[31:24] = 8'd90;
        req = 4'b0000;
        tick();
        chk("ball_x", 32'(x), 80);
        chk("ball_y", 32'(y), 108);
        chk("ball_plot", 32'(plot), 1);
        chk("ball_done", 32'(done), 8);
        tick();

        // Full-screen clear.
        set_job(0, 0, 0, 159, 119, 0);
        req = 4'b0001;
        tick();
        chk("clr_gnt", 32'(gnt), 1);
        req = 4'b0000;
        errs = 0;
        plots = 0;
        done_at = -1;
        for (int n = 0; n < 19200; n++) begin
            tick();
            if (int'(x) != n % 160 || int'(y) != n / 160 || plot !== 1'b1) errs++;
            plots += int'(plot);
            if (done != 4'b0000 && n != 19199) errs++;
            if (done == 4'b0001 && done_at < 0) done_at = n + 1;
        end
        chk("clr_errs", 32'(errs), 0);
        chk("clr_plots", 32'(plots), 19200);
        chk("clr_done_at", 32'(done_at), 19200);
        tick();
        chk("clr_busy_end", 32'(busy), 0);

        // Reset in the middle of a 16x2 job.
        set_job(1, 20, 30, 15, 1, 4);
        req = 4'b0010;
        tick();
        chk("mid_gnt", 32'(gnt), 2);
        req = 4'b0000;
        repeat (5) tick();
        chk("mid_x5", 32'(x), 24);
        chk("mid_plot5", 32'(plot), 1);
        resetn = 1'b0;
        #2 chk_idle_outputs("mid_rst");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_no_done", 32'(done), 0);
        end
        resetn = 1'b1;
        tick();
        chk("mid_idle_busy", 32'(busy), 0);
        chk("mid_idle_done", 32'(done), 0);
        set_job(2, 3, 4, 0, 0, 2);
        req = 4'b0100;
        tick();
        chk("post_gnt", 32'(gnt), 4);
        req = 4'b0000;
        tick();
        chk("post_x", 32'(x), 3);
        chk("post_y", 32'(y), 4);
        chk("post_col", 32'(colour), 2);
        chk("post_done", 32'(done), 4);

        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end

endmodule
